// File: rtl/nn_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_loader_pkg
// Purpose  : Shared types and constants for the nn_data_loader slice:
//            load kind, FSM state encoding, per-load word counts and the
//            packed buffer types.
// Revision : 1.0 - initial release
// ============================================================================
package nn_loader_pkg;

   typedef enum logic {
      LOAD_IMG   = 1'b0,
      LOAD_COEFF = 1'b1
   } load_kind_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int IMG_WORDS   = 16;
   localparam int COEFF_WORDS = 512;
   localparam int WCNT_W      = 9;    // wide enough for COEFF_WORDS-1

   typedef logic [63:0][7:0]    img_buf_t;
   typedef logic [1023:0][15:0] coeff_buf_t;

endpackage
`default_nettype wire

// File: rtl/nn_data_loader_packer.sv
`default_nettype none
// ============================================================================
// Module   : nn_word_packer
// Purpose  : Holds the image and coefficient buffers and writes one 32-bit
//            memory word into the buffer selected by kind at word_idx.
//            Image words carry four bytes, coefficient words two halfwords.
// Ports    : clk, reset_n   - clock, async active-low reset (clears buffers)
//            wr_en          - write one word this cycle
//            kind           - 0: image buffer, 1: coefficient buffer
//            word_idx       - word position within the load
//            wdata          - memory word
//            image_data     - packed image buffer
//            coeff_data     - packed coefficient buffer
// Revision : 1.0 - initial release
// ============================================================================
module nn_word_packer
   import nn_loader_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  wr_en,
   input  logic                  kind,
   input  logic [WCNT_W-1:0]     word_idx,
   input  logic [31:0]           wdata,
   output logic [63:0][7:0]      image_data,
   output logic [1023:0][15:0]   coeff_data
);

   img_buf_t   image_q, image_d;
   coeff_buf_t coeff_q, coeff_d;

   always_comb begin
      image_d = image_q;
      coeff_d = coeff_q;
      if (wr_en) begin
         if (kind == LOAD_COEFF) begin
            coeff_d[{word_idx, 1'b0}] = wdata[15:0];
            coeff_d[{word_idx, 1'b1}] = wdata[31:16];
         end else begin
            for (int k = 0; k < 4; k++) begin
               image_d[{word_idx[3:0], 2'(k)}] = wdata[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         image_q <= '0;
         coeff_q <= '0;
      end else begin
         image_q <= image_d;
         coeff_q <= coeff_d;
      end
   end

   assign image_data = image_q;
   assign coeff_data = coeff_q;

endmodule
`default_nettype wire

// File: rtl/nn_data_loader.sv
`default_nettype none
// ============================================================================
// Module   : nn_data_loader
// Purpose  : Responder for the nn core load handshake. On get_image or
//            get_coeffs it reads 16 / 512 words (one outstanding read) from
//            the word-addressed memory port and packs them into the image /
//            coefficient buffers, holding busy high until complete.
//            A get_image arriving with or during a coefficient load is kept
//            pending and served straight after, with busy held high.
// Ports    : clk, reset_n            - clock, async active-low reset
//            get_coeffs, layer       - coefficient load request + layer
//            get_image               - next-image load request
//            busy                    - load in progress or pending
//            image_data, coeff_data  - packed buffers
//            mem_addr, mem_rd        - read address / one-cycle strobe
//            mem_rdata, mem_rvalid   - read return
//            load_sum                - (NN_LOADER_CHECKSUM_EN only) 16-bit
//                                      wrapping sum of both halfwords of
//                                      every word of the last load
// Options  : NN_LOADER_CHECKSUM_EN adds the load_sum port and accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module nn_data_loader
   import nn_loader_pkg::*;
#(
   parameter int              ADDR_W     = 26,
   parameter int              MEM_DW     = 32,
   parameter logic [ADDR_W-1:0] IMG_BASE   = 26'h0000000,
   parameter logic [ADDR_W-1:0] COEFF_BASE = 26'h0100000,
   parameter int              NUM_IMAGES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  get_coeffs,
   input  logic                  get_image,
   input  logic [1:0]            layer,
   output logic                  busy,
   output logic [63:0][7:0]      image_data,
   output logic [1023:0][15:0]   coeff_data,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic                  mem_rd,
`ifdef NN_LOADER_CHECKSUM_EN
   output logic [15:0]           load_sum,
`endif
   input  logic [MEM_DW-1:0]     mem_rdata,
   input  logic                  mem_rvalid
);

   localparam int IDX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;

   state_t              state_q, state_d;
   load_kind_t          kind_q, kind_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [WCNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]    img_idx_q, img_idx_d;
   logic                pend_q, pend_d;
   logic                busy_q, busy_d;
   logic                mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                wr_en;
   logic [WCNT_W-1:0]   last_word;
   logic [ADDR_W-1:0]   img_base;
`ifdef NN_LOADER_CHECKSUM_EN
   logic [15:0]         sum_q, sum_d;
`endif

   // Each image occupies 16 consecutive words.
   assign img_base  = IMG_BASE + ADDR_W'({img_idx_q, 4'd0});
   assign last_word = (kind_q == LOAD_COEFF) ? WCNT_W'(COEFF_WORDS - 1)
                                             : WCNT_W'(IMG_WORDS - 1);

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      img_idx_d  = img_idx_q;
      pend_d     = pend_q;
      busy_d     = busy_q;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      wr_en      = 1'b0;
`ifdef NN_LOADER_CHECKSUM_EN
      sum_d      = sum_q;
`endif

      // The only request honoured while busy: one image queued behind coefficients.
      if (get_image && (kind_q == LOAD_COEFF) &&
          ((state_q == S_ISSUE) || (state_q == S_WAIT))) begin
         pend_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (get_coeffs || get_image) begin
               if (get_coeffs) begin
                  kind_d = LOAD_COEFF;
                  base_d = COEFF_BASE + ADDR_W'({layer, 9'd0});
                  pend_d = get_image;
               end else begin
                  kind_d = LOAD_IMG;
                  base_d = img_base;
               end
               cnt_d      = '0;
               busy_d     = 1'b1;
               mem_rd_d   = 1'b1;
               mem_addr_d = base_d;
               state_d    = S_ISSUE;
`ifdef NN_LOADER_CHECKSUM_EN
               sum_d      = '0;
`endif
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (mem_rvalid) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
`ifdef NN_LOADER_CHECKSUM_EN
               sum_d = sum_q + mem_rdata[15:0] + mem_rdata[31:16];
`endif
               if (cnt_q == last_word) begin
                  state_d = S_DONE;
                  if (kind_q == LOAD_IMG) begin
                     img_idx_d = (img_idx_q == IDX_W'(NUM_IMAGES - 1)) ? '0
                                                                       : img_idx_q + 1'b1;
                  end
               end else begin
                  state_d    = S_ISSUE;
                  mem_rd_d   = 1'b1;
                  mem_addr_d = base_q + ADDR_W'(cnt_d);
               end
            end
         end
         S_DONE: begin
            if (pend_q) begin
               // Chain straight into the queued image; busy never drops.
               pend_d     = 1'b0;
               kind_d     = LOAD_IMG;
               base_d     = img_base;
               cnt_d      = '0;
               mem_rd_d   = 1'b1;
               mem_addr_d = img_base;
               state_d    = S_ISSUE;
`ifdef NN_LOADER_CHECKSUM_EN
               sum_d      = '0;
`endif
            end else begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         kind_q     <= LOAD_IMG;
         base_q     <= '0;
         cnt_q      <= '0;
         img_idx_q  <= '0;
         pend_q     <= 1'b0;
         busy_q     <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         base_q     <= base_d;
         cnt_q      <= cnt_d;
         img_idx_q  <= img_idx_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
      end
   end

`ifdef NN_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end
   assign load_sum = sum_q;
`endif

   assign busy     = busy_q;
   assign mem_rd   = mem_rd_q;
   assign mem_addr = mem_addr_q;

   nn_word_packer u_packer (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (wr_en),
      .kind       (kind_q),
      .word_idx   (cnt_q),
      .wdata      (mem_rdata[31:0]),
      .image_data (image_data),
      .coeff_data (coeff_data)
   );

endmodule
`default_nettype wire

// File: tb/tb_nn_data_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_data_loader
// Purpose  : Self-checking bench for nn_data_loader. A memory model answers
//            reads after a configurable latency; a reference model computes
//            expected read addresses, buffer contents and latency directly
//            from the load rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_data_loader;

   localparam logic [25:0] C_IMG_BASE   = 26'h0000000;
   localparam logic [25:0] C_COEFF_BASE = 26'h0100000;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                get_coeffs, get_image;
   logic [1:0]          layer;
   logic                busy;
   logic [63:0][7:0]    image_data;
   logic [1023:0][15:0] coeff_data;
   logic [25:0]         mem_addr;
   logic                mem_rd;
   logic [31:0]         mem_rdata;
   logic                mem_rvalid;
`ifdef NN_LOADER_CHECKSUM_EN
   logic [15:0]         load_sum;
   logic [15:0]         exp_sum;
`endif

   nn_data_loader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .get_coeffs (get_coeffs),
      .get_image  (get_image),
      .layer      (layer),
      .busy       (busy),
      .image_data (image_data),
      .coeff_data (coeff_data),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
`ifdef NN_LOADER_CHECKSUM_EN
      .load_sum   (load_sum),
`endif
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          mem_lat  = 1;
   int          mode     = 0;
   logic [31:0] salt     = 32'h0;
   int          glitch_n = 0;
   int          words_sent = 0;
   logic [25:0] rd_q[$];
   logic [25:0] exp_addrs[$];
   logic [7:0]  exp_img[64];
   logic [15:0] exp_coeff[1024];
   int          exp_idx = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Memory contents as a pure function of address and the current test mode.
   function automatic logic [31:0] data_for(input logic [25:0] a);
      logic [31:0] w;
      w = 32'(a[8:0]);
      case (mode)
         1:       return 32'h03020100 + 32'h04040404 * 32'(a[3:0]);
         2:       return {16'(2*w + 1), 16'(2*w)};
         3:       return 32'h00010001;
         default: return (32'(a) * 32'h9E3779B1) ^ salt;
      endcase
   endfunction

   // Memory: one outstanding read, answered mem_lat cycles after the strobe.
   initial begin
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (reset_n && mem_rd) begin
            logic [25:0] a;
            a = mem_addr;
            rd_q.push_back(a);
            repeat (mem_lat) @(posedge clk);
            #1;
            mem_rvalid = 1'b1;
            mem_rdata  = data_for(a);
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            words_sent++;
         end else if (glitch_n > 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            glitch_n--;
         end
      end
   end

   task automatic model_image();
`ifdef NN_LOADER_CHECKSUM_EN
      exp_sum = '0;
`endif
      for (int w = 0; w < 16; w++) begin
         logic [25:0] a;
         logic [31:0] d;
         a = C_IMG_BASE + 26'(exp_idx * 16 + w);
         d = data_for(a);
         exp_addrs.push_back(a);
         for (int k = 0; k < 4; k++) exp_img[4*w + k] = d[8*k +: 8];
`ifdef NN_LOADER_CHECKSUM_EN
         exp_sum = exp_sum + d[15:0] + d[31:16];
`endif
      end
      exp_idx = (exp_idx + 1) % 1024;
   endtask

   task automatic model_coeff(input logic [1:0] lay);
`ifdef NN_LOADER_CHECKSUM_EN
      exp_sum = '0;
`endif
      for (int w = 0; w < 512; w++) begin
         logic [25:0] a;
         logic [31:0] d;
         a = C_COEFF_BASE + 26'(int'(lay) * 512 + w);
         d = data_for(a);
         exp_addrs.push_back(a);
         exp_coeff[2*w]     = d[15:0];
         exp_coeff[2*w + 1] = d[31:16];
`ifdef NN_LOADER_CHECKSUM_EN
         exp_sum = exp_sum + d[15:0] + d[31:16];
`endif
      end
   endtask

   task automatic check_buffers(input string tag);
      int ni = 0;
      int nc = 0;
      for (int i = 0; i < 64; i++)   if (image_data[i] !== exp_img[i])   ni++;
      for (int i = 0; i < 1024; i++) if (coeff_data[i] !== exp_coeff[i]) nc++;
      chk({tag, "_img_bad_bytes"}, 64'(ni), 64'd0);
      chk({tag, "_coeff_bad_words"}, 64'(nc), 64'd0);
   endtask

   task automatic run_load(input string tag, input bit do_img, input bit do_coeff,
                           input logic [1:0] lay, input int lat);
      int n    = 1;
      bit done = 1'b0;
      int nbad = 0;
      mem_lat = lat;
      rd_q.delete();
      exp_addrs.delete();
      @(posedge clk); #1;
      get_image  = do_img;
      get_coeffs = do_coeff;
      layer      = lay;
      @(posedge clk); #1;
      get_image  = 1'b0;
      get_coeffs = 1'b0;
      chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
      for (int c = 0; c < 8000 && !done; c++) begin
         if (c == 7) begin
            layer = ~lay;
            // Pokes that must be ignored during an image-only load.
            if (do_img && !do_coeff) begin
               get_coeffs = 1'b1;
               get_image  = 1'b1;
            end
         end
         if (c == 8) begin
            get_coeffs = 1'b0;
            get_image  = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (!busy) done = 1'b1;
      end
      chk({tag, "_completed"}, 64'(done), 64'd1);
      if (do_coeff) model_coeff(lay);
      if (do_img)   model_image();
      if (!(do_img && do_coeff)) begin
         chk({tag, "_latency"}, 64'(n), 64'(2 + (do_coeff ? 512 : 16) * (1 + lat)));
      end
      chk({tag, "_read_count"}, 64'(rd_q.size()), 64'(exp_addrs.size()));
      for (int i = 0; i < rd_q.size() && i < exp_addrs.size(); i++) begin
         if (rd_q[i] !== exp_addrs[i]) nbad++;
      end
      chk({tag, "_bad_addrs"}, 64'(nbad), 64'd0);
      chk({tag, "_mem_rd_idle"}, 64'(mem_rd), 64'd0);
      check_buffers(tag);
`ifdef NN_LOADER_CHECKSUM_EN
      chk({tag, "_load_sum"}, 64'(load_sum), 64'(exp_sum));
`endif
   endtask

   initial begin
      reset_n    = 1'b0;
      get_coeffs = 1'b0;
      get_image  = 1'b0;
      layer      = 2'd0;
      for (int i = 0; i < 64; i++)   exp_img[i]   = '0;
      for (int i = 0; i < 1024; i++) exp_coeff[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_rd", 64'(mem_rd), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      check_buffers("rst");

      // Image 0 with the byte-ramp pattern, L=1.
      mode = 1;
      run_load("img0", 1'b1, 1'b0, 2'd0, 1);
      chk("img0_byte63", 64'(image_data[63]), 64'd63);
      chk("img0_byte17", 64'(image_data[17]), 64'd17);

      // Layer-2 coefficients with the halfword-ramp pattern, L=1.
      mode = 2;
      run_load("coef2", 1'b0, 1'b1, 2'd2, 1);
      if (rd_q.size() > 0) chk("coef2_first_addr", 64'(rd_q[0]), 64'h100400);
      chk("coef2_word1023", 64'(coeff_data[1023]), 64'd1023);

      // Stray rvalid while idle must not touch the buffers.
      glitch_n = 3;
      repeat (12) @(posedge clk);
      #1;
      check_buffers("glitch");

      // Simultaneous requests: coefficients then chained image, busy continuous.
      mode = 0;
      salt = $urandom;
      run_load("chain", 1'b1, 1'b1, 2'd0, int'($urandom_range(1, 3)));

      // Image with ignored mid-load requests.
      salt = $urandom;
      run_load("img_poke", 1'b1, 1'b0, 2'($urandom_range(0, 3)), int'($urandom_range(1, 3)));

      // Asynchronous reset after five image words.
      begin
         int base = words_sent;
         mem_lat = $urandom_range(1, 3);
         @(posedge clk); #1;
         get_image = 1'b1;
         @(posedge clk); #1;
         get_image = 1'b0;
         for (int c = 0; c < 500 && words_sent < base + 5; c++) @(negedge clk);
         chk("rstmid_words_reached", 64'(words_sent >= base + 5), 64'd1);
         #2;
         reset_n = 1'b0;
         #1;
         for (int i = 0; i < 64; i++)   exp_img[i]   = '0;
         for (int i = 0; i < 1024; i++) exp_coeff[i] = '0;
         exp_idx = 0;
         chk("rstmid_busy", 64'(busy), 64'd0);
         chk("rstmid_mem_rd", 64'(mem_rd), 64'd0);
         chk("rstmid_mem_addr", 64'(mem_addr), 64'd0);
         check_buffers("rstmid");
         repeat (3) @(posedge clk);
         #1;
         reset_n = 1'b1;
         repeat (8) @(posedge clk);
      end
      run_load("img_after_rst", 1'b1, 1'b0, 2'd0, 2);
      if (rd_q.size() > 0) chk("img_after_rst_addr0", 64'(rd_q[0]), 64'd0);

      // Random mix of loads.
      for (int t = 0; t < 5; t++) begin
         bit          is_img;
         logic [1:0]  lay;
         is_img = 1'($urandom_range(0, 1));
         lay    = 2'($urandom_range(0, 3));
         salt   = $urandom;
         run_load(is_img ? "rnd_img" : "rnd_coef", is_img, !is_img, lay,
                  int'($urandom_range(1, 3)));
      end

`ifdef NN_LOADER_CHECKSUM_EN
      mode = 3;
      run_load("sum", 1'b1, 1'b0, 2'd0, 1);
      chk("sum_const32", 64'(load_sum), 64'd32);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
